// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - state_t     : sequencer states (IDLE, CALC, FIXUP, DONE)
//   - OP_MULT/DIV : operation select encoding (matches the control unit)
//   - DEF_WIDTH   : default operand width, DEF_CNT_W: default counter width
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative multiply/divide datapath.
//   MULT: Booth radix-2 over WIDTH steps, product = {raw_hi, raw_lo}.
//   DIV : restoring divide on operand magnitudes, raw_hi = remainder,
//         raw_lo = quotient (both unsigned magnitudes).
// Ports:
//   clock, reset (async active-low)
//   load    : capture operands and operation
//   step    : perform one iteration
//   op_div  : 0 = MULT, 1 = DIV (sampled on load)
//   op_uns  : treat operands as unsigned (sampled on load)
//   a, b    : operands
//   raw_hi, raw_lo : raw result words
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             op_div,
  input  logic             op_uns,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] raw_hi,
  output logic [WIDTH-1:0] raw_lo
);

  // Two guard bits: an unsigned multiplicand can double the accumulator
  // magnitude before the shift, and the divide trial subtraction needs a
  // borrow bit above the W+1-bit shifted remainder.
  logic [WIDTH+1:0] acc;
  logic [WIDTH+1:0] mcand;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic             div_mode;
  logic             mult_corr;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH+1:0] booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;

  assign a_mag = (!op_uns && a[WIDTH-1]) ? -a : a;
  assign b_mag = (!op_uns && b[WIDTH-1]) ? -b : b;

  always_comb begin
    booth_sum = acc;
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
  end

  assign div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign div_trial = {1'b0, div_shift} - mcand;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      mcand     <= '0;
      q         <= '0;
      q_m1      <= 1'b0;
      div_mode  <= 1'b0;
      mult_corr <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      q_m1     <= 1'b0;
      div_mode <= op_div;
      if (op_div) begin
        q         <= a_mag;
        mcand     <= {2'b00, b_mag};
        mult_corr <= 1'b0;
      end else begin
        q         <= b;
        mcand     <= {{2{!op_uns && a[WIDTH-1]}}, a};
        mult_corr <= op_uns && b[WIDTH-1];
      end
    end else if (step) begin
      if (div_mode) begin
        if (!div_trial[WIDTH+1]) begin
          acc <= div_trial;
          q   <= {q[WIDTH-2:0], 1'b1};
        end else begin
          acc <= {1'b0, div_shift};
          q   <= {q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc  <= {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
        q    <= {booth_sum[0], q[WIDTH-1:1]};
        q_m1 <= q[0];
      end
    end
  end

  // Booth over WIDTH steps reads the multiplier as signed; an unsigned
  // multiplier with its top bit set needs the multiplicand added into HI.
  assign raw_hi = mult_corr ? (acc[WIDTH-1:0] + mcand[WIDTH-1:0]) : acc[WIDTH-1:0];
  assign raw_lo = q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle sequencer for the shared iterative multiply/divide engine.
// Accepts one MULT/DIV request in IDLE, iterates WIDTH cycles, fixes signs,
// then pulses done with HI/LO write strobes. DIV by zero skips the engine
// and pulses done + div_zero without writing HI/LO.
// Ports:
//   clock, reset (async active-low)
//   start, mult_or_div (0 = MULT, 1 = DIV), op_a, op_b
//   op_unsigned (only when MULDIV_UNSIGNED_EN is defined)
//   busy, done, div_zero, hi_write, lo_write, hi_out, lo_out
// Build option: MULDIV_UNSIGNED_EN adds op_unsigned for MULTU/DIVU.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mult_or_div,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hi_write,
  output logic             lo_write,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter;
  logic             op_div_q;
  logic             sign_a, sign_b;
  logic             dz_flag;
  logic             accept;
  logic             div_req_zero;
  logic             uns_req;
  logic [WIDTH-1:0] raw_hi, raw_lo;
  logic [WIDTH-1:0] fix_hi, fix_lo;

`ifdef MULDIV_UNSIGNED_EN
  assign uns_req = op_unsigned;
`else
  assign uns_req = 1'b0;
`endif

  assign accept       = (state == IDLE) && start;
  assign div_req_zero = (mult_or_div == OP_DIV) && (op_b == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div_req_zero ? DONE : CALC;
      CALC:    if (counter == CNT_W'(WIDTH - 1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign div_zero = (state == DONE) && dz_flag;
  assign hi_write = (state == DONE) && !dz_flag;
  assign lo_write = (state == DONE) && !dz_flag;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter  <= '0;
      op_div_q <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      dz_flag  <= 1'b0;
    end else if (accept) begin
      counter  <= '0;
      op_div_q <= mult_or_div;
      sign_a   <= !uns_req && op_a[WIDTH-1];
      sign_b   <= !uns_req && op_b[WIDTH-1];
      dz_flag  <= div_req_zero;
    end else if (state == CALC) begin
      counter <= counter + 1'b1;
    end
  end

  muldiv_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clock  (clock),
    .reset  (reset),
    .load   (accept),
    .step   (state == CALC),
    .op_div (mult_or_div),
    .op_uns (uns_req),
    .a      (op_a),
    .b      (op_b),
    .raw_hi (raw_hi),
    .raw_lo (raw_lo)
  );

  // Booth already yields a signed product; only DIV needs sign restoration.
  always_comb begin
    fix_hi = raw_hi;
    fix_lo = raw_lo;
    if (op_div_q) begin
      if (sign_a ^ sign_b) fix_lo = -raw_lo;
      if (sign_a)          fix_hi = -raw_hi;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (state == FIXUP) begin
      hi_out <= fix_hi;
      lo_out <= fix_lo;
    end
  end

endmodule
